key_latch_bank: RTL and testbench
=================================

// Module: key_latch_bank
// PURPOSE
//   Parametrised successor of the enabled key-to-LED register. Per-bit input capture with a built-in strobe divider,
//   2-flop synchroniser, per-bit debounce and four capture modes (follow, hold, toggle, sticky).
//   Sits between board keys/switches and LED/status logic; replaces the separate enable generator + DFF pair.
// PARAMETERS
//   WIDTH     4         number of input/output channels (bits), >= 1
//   DIV       50000     strobe period in clk50m_i cycles, >= 2 (50000 = 1 ms at 50 MHz)
//   DEBOUNCE  3         consecutive equal strobe samples required to accept a new level, >= 1
// PORTS
//   clk50m_i   in   1      system clock, 50 MHz; all logic on rising edge
//   rst_i      in   1      synchronous reset, active-high
//   key_i      in   WIDTH  raw asynchronous key/switch inputs
//   mode_i     in   2      capture mode: 00 FOLLOW, 01 HOLD, 10 TOGGLE, 11 STICKY
//   clr_i      in   1      clear latched outputs (synchronous)
//   led_o      out  WIDTH  latched data (registered)
//   strobe_o   out  1      one-cycle enable pulse every DIV cycles (registered)
//   changed_o  out  1      one-cycle pulse: led_o took a new value this cycle
// BEHAVIOUR
//   Reset (rst_i=1 at rising edge): div counter, synchroniser, all debounce state, led_o, strobe_o, changed_o <= 0.
//   Divider: counter 0..DIV-1, +1 per cycle, wraps to 0. strobe_o=1 in the cycle after counter==DIV-1;
//     first pulse DIV cycles after the first non-reset edge, then exactly every DIV cycles.
//   Synchroniser: key_i -> 2 flops every cycle; debounce sees sync output (2-cycle latency).
//   Debounce (per bit, evaluated only on strobe cycles): cand, cnt ($clog2(DEBOUNCE+1) bits), stable.
//     sample != cand -> cand<=sample, cnt<=1; else cnt<=min(cnt+1,DEBOUNCE) (saturates, no wrap).
//     New level accepted (stable<=cand) on the strobe where cnt reaches DEBOUNCE and cand != stable.
//     DEBOUNCE=1: accepted on first strobe that samples a differing level.
//     rise[i]=1 on the accepting strobe when stable goes 0->1; fall is tracked but drives no event.
//   Output update, on the same strobe cycle, visible on led_o next cycle; mode_i sampled on that strobe only:
//     FOLLOW: led_o <= new stable vector.  HOLD: led_o unchanged (debounce keeps running).
//     TOGGLE: led_o[i] <= led_o[i] ^ rise[i].  STICKY: led_o[i] <= led_o[i] | rise[i].
//   Changing mode_i never alters led_o by itself; FOLLOW re-syncs led_o to stable on next strobe.
//   clr_i=1: led_o <= 0 at that edge regardless of strobe/mode; beats mode update in same cycle;
//     debounce state untouched (a held key does not re-trigger TOGGLE/STICKY after clear).
//   Priority: rst_i > clr_i > mode update.
//   changed_o: registered, 1 exactly in cycles where led_o differs from its previous-cycle value
//     (incl. clr_i clearing nonzero data); 0 when clr_i hits already-zero data.
//   No internal state beyond the above; all bits independent except shared divider/strobe.
//   Reset mid-debounce discards partial counts; a key held through reset is re-accepted after
//     sync + DEBOUNCE strobes like a fresh press.
// TESTING (bench uses DIV=4, DEBOUNCE=2, WIDTH=4)
//   1 Reset: rst_i=1 5 cycles, key_i=4'hF -> led_o=0, strobe_o=0, changed_o=0 throughout; then strobe_o
//     period 4, first pulse 4 cycles after release.
//   2 FOLLOW: key_i=4'b0101 held -> led_o=4'b0101 one cycle after 2nd strobe sampling synced value,
//     changed_o one pulse; key_i=0 -> led_o=0 after 2 more strobes.
//   3 Bounce: bit0 alternates every strobe for 6 strobes then settles to 1 -> led_o[0] stays 0 until
//     2 equal strobes, then 1; exactly one changed_o pulse.
//   4 TOGGLE: mode=10, three clean presses/releases on bit2 -> led_o[2] = 1,0,1; releases cause no change.
//   5 STICKY+clr: mode=11, press bit1 and bit3 -> led_o=4'b1010; clr_i 1 cycle while held -> led_o=0,
//     changed_o pulse, no re-set while keys held; release/press bit1 -> 4'b0010.
//   6 HOLD/priority: FOLLOW at 4'b0011, mode=01, key_i=4'b1100 -> led_o stays 0011; clr_i and accepting
//     strobe same cycle -> led_o=0; rst_i mid-debounce -> all outputs 0 next cycle.

Source files
------------

// File: rtl/key_latch_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : key_latch_bank_if
// Brief   : Key/mode/clear inputs and latched LED/status outputs of key_latch_bank.
// Revision: 1.0 - initial release
// ============================================================================
interface key_latch_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] key_i;
    logic [1:0]       mode_i;
    logic             clr_i;
    logic [WIDTH-1:0] led_o;
    logic             strobe_o;
    logic             changed_o;

    modport master (
        output key_i, mode_i, clr_i,
        input  led_o, strobe_o, changed_o
    );

    modport slave (
        input  key_i, mode_i, clr_i,
        output led_o, strobe_o, changed_o
    );
endinterface
`default_nettype wire

// File: rtl/key_latch_bank.sv
`default_nettype none
// ============================================================================
// Module  : key_latch_bank
// Brief   : Strobed, synchronised, debounced key capture with follow/hold/toggle/sticky LED latching.
// Revision: 1.0 - initial release
// ============================================================================
module key_latch_bank #(
    parameter int WIDTH    = 4,
    parameter int DIV      = 50000,
    parameter int DEBOUNCE = 3
) (
    input  wire logic         clk50m_i,
    input  wire logic         rst_i,
    key_latch_bank_if.slave   bus
);
    localparam int c_div_w = $clog2(DIV);
    localparam int c_cnt_w = $clog2(DEBOUNCE + 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE);

    localparam logic [1:0] c_mode_follow = 2'b00;
    localparam logic [1:0] c_mode_hold   = 2'b01;
    localparam logic [1:0] c_mode_toggle = 2'b10;
    localparam logic [1:0] c_mode_sticky = 2'b11;

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_strobe;
    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_led;
    logic               r_changed;
    logic [WIDTH-1:0]   w_stable_nxt;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_led_nxt;

    always_ff @(posedge clk50m_i) begin
        if (rst_i) begin
            r_div_cnt <= '0;
            r_strobe  <= 1'b0;
            r_sync1   <= '0;
            r_sync2   <= '0;
        end else begin
            r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + 1'b1;
            r_strobe  <= (r_div_cnt == c_div_last);
            r_sync1   <= bus.key_i;
            r_sync2   <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic               r_cand;
            logic               r_stable;
            logic [c_cnt_w-1:0] r_cnt;
            logic               w_cand_nxt;
            logic [c_cnt_w-1:0] w_cnt_nxt;
            logic               w_accept;

            // Acceptance is judged on the post-update count so DEBOUNCE=1 accepts on the first differing sample.
            always_comb begin
                w_cand_nxt = r_cand;
                w_cnt_nxt  = r_cnt;
                if (r_sync2[gi] != r_cand) begin
                    w_cand_nxt = r_sync2[gi];
                    w_cnt_nxt  = c_cnt_w'(1);
                end else if (r_cnt != c_cnt_max) begin
                    w_cnt_nxt  = r_cnt + 1'b1;
                end
                w_accept = r_strobe && (w_cnt_nxt == c_cnt_max) && (w_cand_nxt != r_stable);
            end

            always_ff @(posedge clk50m_i) begin
                if (rst_i) begin
                    r_cand   <= 1'b0;
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (r_strobe) begin
                    r_cand <= w_cand_nxt;
                    r_cnt  <= w_cnt_nxt;
                    if (w_accept) begin
                        r_stable <= w_cand_nxt;
                    end
                end
            end

            assign w_stable_nxt[gi] = w_accept ? w_cand_nxt : r_stable;
            assign w_rise[gi]       = w_accept & w_cand_nxt;
        end
    endgenerate

    // Clear outranks any strobe-time mode update.
    always_comb begin
        w_led_nxt = r_led;
        if (bus.clr_i) begin
            w_led_nxt = '0;
        end else if (r_strobe) begin
            case (bus.mode_i)
                c_mode_follow: w_led_nxt = w_stable_nxt;
                c_mode_hold:   w_led_nxt = r_led;
                c_mode_toggle: w_led_nxt = r_led ^ w_rise;
                c_mode_sticky: w_led_nxt = r_led | w_rise;
                default:       w_led_nxt = r_led;
            endcase
        end
    end

    always_ff @(posedge clk50m_i) begin
        if (rst_i) begin
            r_led     <= '0;
            r_changed <= 1'b0;
        end else begin
            r_led     <= w_led_nxt;
            r_changed <= (w_led_nxt != r_led);
        end
    end

    assign bus.led_o     = r_led;
    assign bus.strobe_o  = r_strobe;
    assign bus.changed_o = r_changed;
endmodule
`default_nettype wire

// File: tb/tb_key_latch_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_latch_bank
// Brief   : Directed self-checking bench for key_latch_bank (DIV=4, DEBOUNCE=2, WIDTH=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_key_latch_bank;
    logic clk50m_i;
    logic rst_i;
    int   n_checks;
    int   n_errors;

    key_latch_bank_if #(.WIDTH(4)) bus ();

    key_latch_bank #(
        .WIDTH    (4),
        .DIV      (4),
        .DEBOUNCE (2)
    ) dut (
        .clk50m_i (clk50m_i),
        .rst_i    (rst_i),
        .bus      (bus)
    );

    initial clk50m_i = 1'b0;
    always #5 clk50m_i = ~clk50m_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk50m_i);
        #1;
    endtask

    // Stop in the cycle where strobe_o is high.
    task automatic to_strobe();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (bus.strobe_o !== 1'b1 && k < 8);
        chk("strobe_seen", {31'd0, bus.strobe_o}, 32'd1);
    endtask

    // Stop just after the edge that applies a strobe's update.
    task automatic su();
        to_strobe();
        step();
    endtask

    task automatic chk_out(input string tag, input logic [3:0] led, input logic chg);
        chk({tag, "_led"}, {28'd0, bus.led_o}, {28'd0, led});
        chk({tag, "_chg"}, {31'd0, bus.changed_o}, {31'd0, chg});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_i       = 1'b1;
        bus.key_i   = 4'hF;
        bus.mode_i  = 2'b00;
        bus.clr_i   = 1'b0;

        // 1: reset holds everything low, then strobe every 4 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("rst", 4'h0, 1'b0);
            chk("rst_strobe", {31'd0, bus.strobe_o}, 32'd0);
        end
        rst_i     = 1'b0;
        bus.key_i = 4'h0;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("strobe_period", {31'd0, bus.strobe_o}, (i % 4 == 0) ? 32'd1 : 32'd0);
        end

        // 2: FOLLOW
        su();
        bus.key_i = 4'b0101;
        su();
        chk_out("follow_s1", 4'h0, 1'b0);
        su();
        chk_out("follow_s2", 4'b0101, 1'b1);
        step();
        chk_out("follow_hold", 4'b0101, 1'b0);
        bus.key_i = 4'b0000;
        su();
        chk_out("follow_rel1", 4'b0101, 1'b0);
        su();
        chk_out("follow_rel2", 4'b0000, 1'b1);

        // 3: bounce on bit0
        for (int i = 0; i < 6; i++) begin
            bus.key_i = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            su();
            chk_out("bounce", 4'h0, 1'b0);
        end
        bus.key_i = 4'b0001;
        su();
        chk_out("bounce_settle1", 4'h0, 1'b0);
        su();
        chk_out("bounce_settle2", 4'b0001, 1'b1);
        step();
        chk_out("bounce_once", 4'b0001, 1'b0);
        su();
        chk_out("bounce_quiet", 4'b0001, 1'b0);

        // 4: TOGGLE on bit2, bit0 held high
        bus.mode_i = 2'b10;
        bus.key_i  = 4'b0101;
        su(); su();
        chk_out("tog_p1", 4'b0101, 1'b1);
        bus.key_i = 4'b0001;
        su(); su();
        chk_out("tog_r1", 4'b0101, 1'b0);
        bus.key_i = 4'b0101;
        su(); su();
        chk_out("tog_p2", 4'b0001, 1'b1);
        bus.key_i = 4'b0001;
        su(); su();
        chk_out("tog_r2", 4'b0001, 1'b0);
        bus.key_i = 4'b0101;
        su(); su();
        chk_out("tog_p3", 4'b0101, 1'b1);

        // 5: STICKY and clear
        bus.mode_i = 2'b11;
        bus.key_i  = 4'b0000;
        bus.clr_i  = 1'b1;
        step();
        chk_out("stk_clr0", 4'h0, 1'b1);
        bus.clr_i = 1'b0;
        su(); su();
        chk_out("stk_release", 4'h0, 1'b0);
        bus.key_i = 4'b1010;
        su();
        chk_out("stk_p_s1", 4'h0, 1'b0);
        su();
        chk_out("stk_p_s2", 4'b1010, 1'b1);
        bus.clr_i = 1'b1;
        step();
        chk_out("stk_clr_held", 4'h0, 1'b1);
        step();
        chk_out("stk_clr_zero", 4'h0, 1'b0);
        bus.clr_i = 1'b0;
        su(); su();
        chk_out("stk_no_retrig", 4'h0, 1'b0);
        bus.key_i = 4'b1000;
        su(); su();
        chk_out("stk_rel_b1", 4'h0, 1'b0);
        bus.key_i = 4'b1010;
        su(); su();
        chk_out("stk_repress_b1", 4'b0010, 1'b1);

        // 6: FOLLOW resync, HOLD, clear vs accepting strobe, reset mid-debounce
        bus.mode_i = 2'b00;
        bus.key_i  = 4'b0011;
        su();
        chk_out("resync", 4'b1010, 1'b1);
        su();
        chk_out("follow_0011", 4'b0011, 1'b1);
        bus.mode_i = 2'b01;
        bus.key_i  = 4'b1100;
        su(); su();
        chk_out("hold", 4'b0011, 1'b0);
        bus.mode_i = 2'b00;
        bus.key_i  = 4'b0011;
        su();
        chk_out("hold_exit_resync", 4'b1100, 1'b1);
        to_strobe();
        bus.clr_i = 1'b1;
        step();
        chk_out("clr_beats_accept", 4'h0, 1'b1);
        bus.clr_i = 1'b0;
        su();
        chk_out("after_clr_follow", 4'b0011, 1'b1);
        bus.key_i = 4'b1111;
        su();
        chk_out("pre_rst", 4'b0011, 1'b0);
        step();
        rst_i = 1'b1;
        step();
        chk_out("mid_rst", 4'h0, 1'b0);
        chk("mid_rst_strobe", {31'd0, bus.strobe_o}, 32'd0);
        rst_i = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("rearm_led", {28'd0, bus.led_o}, (i == 9) ? 32'hF : 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
